// File: rtl/turn_signal_seq_if.sv
// Switch-side requests and lamp-side outputs of the turn-signal sequencer.
// The brake input exists only when TURN_SEQ_BRAKE_EN is defined.
interface turn_signal_seq_if #(
  parameter int LAMPS = 3
);
  logic             left;
  logic             right;
  logic             hazard;
`ifdef TURN_SEQ_BRAKE_EN
  logic             brake;
`endif
  logic [LAMPS-1:0] L;
  logic [LAMPS-1:0] R;
  logic             busy;

`ifdef TURN_SEQ_BRAKE_EN
  modport master (output left, right, hazard, brake, input L, R, busy);
  modport slave  (input left, right, hazard, brake, output L, R, busy);
`else
  modport master (output left, right, hazard, input L, R, busy);
  modport slave  (input left, right, hazard, output L, R, busy);
`endif
endinterface

// File: rtl/turn_signal_seq.sv
// Sequential turn-signal / hazard lamp controller.
// Progressive fill on turn requests, both-bank flash on hazard; every pattern
// step lasts TICK_DIV clocks. Optional brake overlay: TURN_SEQ_BRAKE_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | lamps dark, sampling left/right/hazard every cycle
// RUN     | filling active side(s), `step` lamps lit from the inside out
// OFF     | all dark for one step period before returning to IDLE
// HAZ_ON  | both banks fully lit for one step period
// HAZ_OFF | both banks dark for one step period
module turn_signal_seq #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 1
) (
  input  logic                clk,
  input  logic                reset,
  turn_signal_seq_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, RUN, OFF, HAZ_ON, HAZ_OFF} state_t;
  typedef enum logic [1:0] {M_LEFT, M_RIGHT, M_BOTH} mode_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  STEP_LAST = 4'(LAMPS);

  state_t      state, state_n;
  mode_t       mode, mode_n;
  logic [3:0]  step, step_n;
  logic [15:0] tick, tick_n;
  logic        boundary;

  assign boundary = (tick == TICK_LAST);

  // State, mode, step and tick registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mode  <= M_LEFT;
      step  <= 4'd1;
      tick  <= '0;
    end else begin
      state <= state_n;
      mode  <= mode_n;
      step  <= step_n;
      tick  <= tick_n;
    end
  end

  // Next-state logic; the tick counter restarts whenever state or step moves.
  always_comb begin
    state_n = state;
    mode_n  = mode;
    step_n  = step;
    tick_n  = boundary ? '0 : tick + 16'd1;
    unique case (state)
      IDLE: begin
        tick_n = '0;
        step_n = 4'd1;
        if (bus.hazard) begin
          state_n = HAZ_ON;
        end else if (bus.left && bus.right) begin
          state_n = RUN;
          mode_n  = M_BOTH;
        end else if (bus.left) begin
          state_n = RUN;
          mode_n  = M_LEFT;
        end else if (bus.right) begin
          state_n = RUN;
          mode_n  = M_RIGHT;
        end
      end
      RUN: begin
        if (boundary) begin
          if (bus.hazard)             state_n = HAZ_ON;
          else if (step < STEP_LAST)  step_n  = step + 4'd1;
          else                        state_n = OFF;
        end
      end
      OFF: begin
        if (boundary) state_n = bus.hazard ? HAZ_ON : IDLE;
      end
      HAZ_ON: begin
        if (boundary) state_n = bus.hazard ? HAZ_OFF : IDLE;
      end
      HAZ_OFF: begin
        if (boundary) state_n = bus.hazard ? HAZ_ON : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [LAMPS-1:0] fill;
  logic             left_act, right_act;

  // Lamp decode from registered state; brake only lights sides not sequencing.
  always_comb begin
    fill      = ~({LAMPS{1'b1}} << step);
    left_act  = (state == RUN) && (mode != M_RIGHT);
    right_act = (state == RUN) && (mode != M_LEFT);
    bus.L     = '0;
    bus.R     = '0;
    bus.busy  = (state != IDLE);
    if (state == HAZ_ON) begin
      bus.L = '1;
      bus.R = '1;
    end else begin
      if (left_act)  bus.L = fill;
      if (right_act) bus.R = fill;
`ifdef TURN_SEQ_BRAKE_EN
      if (bus.brake && (state != HAZ_OFF)) begin
        if (!left_act)  bus.L = '1;
        if (!right_act) bus.R = '1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_turn_signal_seq.sv
// Self-checking bench for turn_signal_seq (LAMPS=3, TICK_DIV=2).
// Reference model tracks elapsed cycles within a sequence and derives the
// lamp pattern arithmetically from that count.
module tb_turn_signal_seq;
  localparam int LAMPS = 3;
  localparam int TD    = 2;

  logic clk = 1'b0;
  logic reset;
  logic tb_brake;
  always #5 clk = ~clk;

  turn_signal_seq_if #(.LAMPS(LAMPS)) bus ();

  turn_signal_seq #(.LAMPS(LAMPS), .TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef TURN_SEQ_BRAKE_EN
  assign bus.brake = tb_brake;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // model: kind 0 idle, 1 turn sequence, 2 hazard flashing
  int   m_kind = 0;
  int   m_cnt  = 0;
  logic m_l    = 1'b0;
  logic m_r    = 1'b0;
  logic [LAMPS-1:0] exp_l, exp_r;
  logic             exp_busy;

  function automatic logic [LAMPS-1:0] ones(input int k);
    logic [LAMPS-1:0] v;
    v = '0;
    for (int i = 0; i < LAMPS; i++) if (i < k) v[i] = 1'b1;
    return v;
  endfunction

  task automatic cyc(input logic l, input logic r, input logic h,
                     input logic b, input logic rs);
    logic [LAMPS-1:0] pat;
    bus.left   = l;
    bus.right  = r;
    bus.hazard = h;
    tb_brake   = b;
    reset      = rs;
    @(posedge clk);
    if (rs) begin
      m_kind = 0;
      m_cnt  = 0;
    end else begin
      case (m_kind)
        0: begin
          m_cnt = 0;
          if (h) m_kind = 2;
          else if (l || r) begin
            m_kind = 1;
            m_l    = l;
            m_r    = r;
          end
        end
        1: begin
          if (m_cnt % TD == TD - 1) begin
            if (h) begin
              m_kind = 2;
              m_cnt  = 0;
            end else if (m_cnt == (LAMPS + 1) * TD - 1) begin
              m_kind = 0;
              m_cnt  = 0;
            end else m_cnt++;
          end else m_cnt++;
        end
        default: begin
          if (m_cnt % TD == TD - 1 && !h) begin
            m_kind = 0;
            m_cnt  = 0;
          end else m_cnt++;
        end
      endcase
    end
    #1;
    exp_l    = '0;
    exp_r    = '0;
    exp_busy = (m_kind != 0);
    if (m_kind == 1) begin
      pat   = (m_cnt < LAMPS * TD) ? ones(m_cnt / TD + 1) : '0;
      exp_l = m_l ? pat : '0;
      exp_r = m_r ? pat : '0;
    end else if (m_kind == 2) begin
      pat   = ((m_cnt / TD) % 2 == 0) ? '1 : '0;
      exp_l = pat;
      exp_r = pat;
    end
`ifdef TURN_SEQ_BRAKE_EN
    if (b && m_kind != 2) begin
      if (m_kind == 0 || m_cnt >= LAMPS * TD) begin
        exp_l = '1;
        exp_r = '1;
      end else begin
        if (!m_l) exp_l = '1;
        if (!m_r) exp_r = '1;
      end
    end
`endif
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      tests_run++;
      if ({bus.L, bus.R, bus.busy} !== {LAMPS'(0), LAMPS'(0), 1'b0}) begin
        tests_failed++;
        $display("FAIL reset: L=%b R=%b busy=%b, required all zero", bus.L, bus.R, bus.busy);
      end
    end
  endtask

  task automatic test_left_held();
    for (int i = 0; i < 2 * ((LAMPS + 1) * TD + 1); i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if ({bus.L, bus.R, bus.busy} !== {exp_l, exp_r, exp_busy}) begin
        tests_failed++;
        $display("FAIL left_held cyc %0d: L=%b R=%b busy=%b, required L=%b R=%b busy=%b",
                 i, bus.L, bus.R, bus.busy, exp_l, exp_r, exp_busy);
      end
    end
    tests_run++;
    if (bus.L !== 3'b000 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL left_held idle: L=%b busy=%b, required 000/0", bus.L, bus.busy);
    end
  endtask

  task automatic test_both_drop_right();
    logic [LAMPS-1:0] seen [$];
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < (LAMPS + 1) * TD + 1; i++) begin
      cyc(1'b1, (i < 2), 1'b0, 1'b0, 1'b0);
      seen.push_back(bus.R);
      tests_run++;
      if ({bus.L, bus.R, bus.busy} !== {exp_l, exp_r, exp_busy}) begin
        tests_failed++;
        $display("FAIL both_drop_right cyc %0d: L=%b R=%b busy=%b, required L=%b R=%b busy=%b",
                 i, bus.L, bus.R, bus.busy, exp_l, exp_r, exp_busy);
      end
    end
    tests_run++;
    if (seen[2 * TD + 1] !== 3'b111) begin
      tests_failed++;
      $display("FAIL both_drop_right fill: R=%b, required 111", seen[2 * TD + 1]);
    end
  endtask

  task automatic test_hazard_abort();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, (i >= 1 && i < 12), 1'b0, 1'b0);
      tests_run++;
      if ({bus.L, bus.R, bus.busy} !== {exp_l, exp_r, exp_busy}) begin
        tests_failed++;
        $display("FAIL hazard_abort cyc %0d: L=%b R=%b busy=%b, required L=%b R=%b busy=%b",
                 i, bus.L, bus.R, bus.busy, exp_l, exp_r, exp_busy);
      end
    end
  endtask

  task automatic test_hazard_priority();
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, (i < 3), 1'b0, 1'b0);
      tests_run++;
      if ({bus.L, bus.R, bus.busy} !== {exp_l, exp_r, exp_busy} ||
          (i == 0 && bus.R !== 3'b111)) begin
        tests_failed++;
        $display("FAIL hazard_priority cyc %0d: L=%b R=%b busy=%b, required L=%b R=%b busy=%b",
                 i, bus.L, bus.R, bus.busy, exp_l, exp_r, exp_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, (i == 3));
      tests_run++;
      if ({bus.L, bus.R, bus.busy} !== {exp_l, exp_r, exp_busy}) begin
        tests_failed++;
        $display("FAIL reset_mid cyc %0d: L=%b R=%b busy=%b, required L=%b R=%b busy=%b",
                 i, bus.L, bus.R, bus.busy, exp_l, exp_r, exp_busy);
      end
    end
  endtask

  task automatic test_pulse();
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < (LAMPS + 1) * TD + 3; i++) begin
      cyc((i == 0), 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if ({bus.L, bus.R, bus.busy} !== {exp_l, exp_r, exp_busy}) begin
        tests_failed++;
        $display("FAIL pulse cyc %0d: L=%b R=%b busy=%b, required L=%b R=%b busy=%b",
                 i, bus.L, bus.R, bus.busy, exp_l, exp_r, exp_busy);
      end
    end
  endtask

`ifdef TURN_SEQ_BRAKE_EN
  task automatic test_brake();
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 1'b1, (i >= 20 && i < 24), 1'b1, 1'b0);
      tests_run++;
      if ({bus.L, bus.R, bus.busy} !== {exp_l, exp_r, exp_busy}) begin
        tests_failed++;
        $display("FAIL brake cyc %0d: L=%b R=%b busy=%b, required L=%b R=%b busy=%b",
                 i, bus.L, bus.R, bus.busy, exp_l, exp_r, exp_busy);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic l, r, h, b;
    int   hold;
    l = 0; r = 0; h = 0; b = 0; hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        l    = ($urandom_range(0, 2) == 0);
        r    = ($urandom_range(0, 2) == 0);
        h    = ($urandom_range(0, 5) == 0);
        b    = ($urandom_range(0, 3) == 0);
        hold = $urandom_range(0, 9);
      end else hold--;
      cyc(l, r, h, b, ($urandom_range(0, 199) == 0));
      tests_run++;
      if ({bus.L, bus.R, bus.busy} !== {exp_l, exp_r, exp_busy}) begin
        tests_failed++;
        $display("FAIL random cyc %0d: L=%b R=%b busy=%b, required L=%b R=%b busy=%b",
                 i, bus.L, bus.R, bus.busy, exp_l, exp_r, exp_busy);
      end
    end
  endtask

  initial begin
    bus.left   = 1'b0;
    bus.right  = 1'b0;
    bus.hazard = 1'b0;
    tb_brake   = 1'b0;
    reset      = 1'b1;
    test_reset();
    test_left_held();
    test_both_drop_right();
    test_hazard_abort();
    test_hazard_priority();
    test_reset_mid();
    test_pulse();
`ifdef TURN_SEQ_BRAKE_EN
    test_brake();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/turn_signal_seq.md
# turn_signal_seq

Parametrised sequential turn-signal / hazard lamp controller for the vehicle-lighting path. Drives two banks of LAMPS lamps (left and right) with a progressive fill pattern on turn requests, flashes both banks on hazard, and runs each pattern step for a programmable number of clock cycles. Sits between the debounced switch inputs and the lamp drivers.

## Interface
Parameters:
- LAMPS, 3: lamps per side; legal range 1..15.
- TICK_DIV, 1: clock cycles per pattern step; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- left  input  1  left turn request (level).
- right  input  1  right turn request (level).
- hazard  input  1  hazard request (level); highest priority.
- brake  input  1  brake pedal (level); present only with TURN_SEQ_BRAKE_EN.
- L  output  LAMPS  left lamps; bit 0 innermost.
- R  output  LAMPS  right lamps; bit 0 innermost.
- busy  output  1  high whenever state is not IDLE.

## Operation
- States: IDLE, RUN, OFF, HAZ_ON, HAZ_OFF. Registers: state, mode (2 bits: LEFT, RIGHT, BOTH), step (1..LAMPS), tick counter (0..TICK_DIV-1).
- Outputs are Moore, decoded from registered state only.
- IDLE: L=R=0. Sample inputs every cycle. Priority: hazard -> HAZ_ON; else left&right -> RUN/BOTH; else left -> RUN/LEFT; else right -> RUN/RIGHT; else stay. Entering RUN sets step=1, tick=0.
- RUN: active side(s) drive lower `step` bits high (step k -> k ones, e.g. LAMPS=3: 001, 011, 111); inactive side 0. mode latched at entry; left/right changes ignored until IDLE.
- Step boundary = tick counter at TICK_DIV-1. At boundary: if hazard -> HAZ_ON (abort); else if step<LAMPS -> step+1; else -> OFF.
- OFF: L=R=0 for TICK_DIV cycles, then IDLE. Hazard at OFF boundary -> HAZ_ON.
- HAZ_ON: L=R=all ones; HAZ_OFF: L=R=0. Each lasts TICK_DIV cycles. At boundary: hazard high -> toggle to other phase; hazard low -> IDLE.
- Tick counter clears on every state or step change; never wraps mid-step.
- Reset (any state, any cycle): next edge forces IDLE, step=1, tick=0, mode=LEFT; L=R=0, busy=0.

## Timing
- Request held in IDLE at edge n: RUN step 1 visible after edge n+1.
- TICK_DIV=1, LAMPS=3, left held: cycles after request 1..4 show L=001,011,111,000, then IDLE one cycle (000) sampling again; period LAMPS+2 cycles.
- General period with held request: (LAMPS+1)*TICK_DIV + 1 cycles.
- Hazard abort latency from RUN/OFF: at most TICK_DIV cycles (next boundary).
- Hazard release latency: at most TICK_DIV cycles; IDLE then resamples left/right normally.
- Simultaneous hazard+left+right in IDLE: hazard wins.
- Pulse request shorter than one cycle in IDLE sampled only if high at a clk edge; sequence then completes fully regardless of input.

## Configuration
- TURN_SEQ_BRAKE_EN defined: brake port exists. In IDLE, RUN and OFF, any side not being sequenced (whole side in IDLE/OFF, inactive side in RUN) drives all ones while brake=1. Sequencing side unaffected. HAZ_ON/HAZ_OFF ignore brake. brake has no effect on state transitions.
- TURN_SEQ_BRAKE_EN undefined: no brake port; behaviour as Operation.

## Test plan
- Reset mid-sequence: LAMPS=3, TICK_DIV=1, left high, assert reset at RUN step 2 -> next cycle L=R=000, busy=0; after release with left held, L=001 one cycle later.
- Left held, LAMPS=4, TICK_DIV=2 -> L=0001,0001,0011,0011,0111,0111,1111,1111,0000,0000,0000(IDLE), repeat; R=0000 throughout.
- left&right together at one edge, LAMPS=3 -> L and R both 001,011,111,000; dropping right mid-run keeps both sequencing to completion.
- Hazard raised in RUN step 1, TICK_DIV=3 -> within 3 cycles L=R=111 for 3 cycles, 000 for 3 cycles, alternating; hazard dropped -> IDLE within 3 cycles, busy=0.
- Hazard and right asserted in same IDLE cycle -> HAZ_ON (L=R=111), never R=001.
- With TURN_SEQ_BRAKE_EN, brake=1, right held, LAMPS=3 -> L=111 constant, R=001,011,111; in OFF/IDLE L=R=111; during hazard brake ignored (L=R flash 111/000).
